// File: rtl/rip128_result_drain.sv
// Result stage for the pipelined 128-bit ripple adder: latency-matched valid tracking, DEPTH-entry result FIFO,
// 4x32-bit valid/ready drain. Define RIP128_DRAIN_CREDIT_EN to gate launches with credit-based in_ready.
module rip128_result_drain #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] sum,
  input  logic         cout,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         out_cout,
  output logic         ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [128:0]       mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [1:0]         widx_q, widx_d;
  logic               ovf_q, ovf_d;

  logic               launch;
  logic               refused;
  logic               capture_req;
  logic               push;
  logic               pop;
  logic               beat;
  logic               fifo_empty;
  logic               fifo_full;
  logic [128:0]       head;

`ifdef RIP128_DRAIN_CREDIT_EN
  // Launched-but-not-drained results: valid-line occupancy plus FIFO fill.
  logic [AW:0] outst_q, outst_d;

  assign in_ready = (outst_q < FULL_CNT);
  assign launch   = in_valid & in_ready;
  assign refused  = in_valid & ~in_ready;

  always_comb begin
    outst_d = outst_q;
    case ({launch, pop})
      2'b10:   outst_d = outst_q + (AW+1)'(1);
      2'b01:   outst_d = outst_q - (AW+1)'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end
`else
  assign in_ready = 1'b1;
  assign launch   = in_valid;
  assign refused  = 1'b0;
`endif

  generate
    if (LATENCY == 1) begin : g_pipe_one
      assign vld_pipe_d = launch;
    end else begin : g_pipe_many
      assign vld_pipe_d = {vld_pipe_q[LATENCY-2:0], launch};
    end
  endgenerate

  assign capture_req = vld_pipe_q[LATENCY-1];
  assign fifo_empty  = (cnt_q == '0);
  assign fifo_full   = (cnt_q == FULL_CNT);
  assign beat        = out_valid & out_ready;
  assign pop         = beat & (widx_q == 2'd3);
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push        = capture_req & (~fifo_full | pop);
  assign head        = mem_q[rptr_q];

  assign out_valid = ~fifo_empty;
  assign out_last  = out_valid & (widx_q == 2'd3);
  assign out_cout  = out_valid & head[128];
  assign ovf       = ovf_q;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (widx_q)
        2'd0:    out_data = head[31:0];
        2'd1:    out_data = head[63:32];
        2'd2:    out_data = head[95:64];
        default: out_data = head[127:96];
      endcase
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    widx_d = widx_q;
    ovf_d  = ovf_q | refused | (capture_req & ~push);
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (beat) begin
      widx_d = widx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      widx_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {cout, sum};
    end
  end

endmodule
